execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 199 +++++++++++++++++++
 tb/tb_execute_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : execute_stage                                                |
// | Description : Integer execute stage. Takes a decode bundle through a       |
// |               valid/ready handshake and produces a registered ALU result   |
// |               with single-cycle latency. When the EX_MUL_EN macro is       |
// |               defined, a 32-cycle shift-add multiplier is included for     |
// |               MUL; otherwise MUL is retired as a NOP.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module execute_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic [106:0] id_ex,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   out_opcode,
  output logic [31:0]  out_result,
  output logic [4:0]   out_dest,
  output logic         out_wen
);

  localparam logic [1:0] c_st_idle     = 2'd0;
`ifdef EX_MUL_EN
  localparam logic [1:0] c_st_mul_busy = 2'd1;
  localparam logic [1:0] c_st_done     = 2'd2;
  localparam logic [5:0] c_op_mul      = 6'b000101;
`endif

  localparam logic [5:0] c_op_add  = 6'b000000;
  localparam logic [5:0] c_op_sub  = 6'b000001;
  localparam logic [5:0] c_op_and  = 6'b000010;
  localparam logic [5:0] c_op_or   = 6'b000011;
  localparam logic [5:0] c_op_slt  = 6'b000100;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_subi = 6'b001001;
  localparam logic [5:0] c_op_andi = 6'b001010;
  localparam logic [5:0] c_op_ori  = 6'b001011;
  localparam logic [5:0] c_op_slti = 6'b001100;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic [5:0]  w_opcode;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_dest;
  logic [31:0] w_imm;
  logic [31:0] w_op2;
  logic [31:0] w_alu_result;
  logic        w_alu_known;
  logic        w_accept;
  logic        w_load_alu;

  logic        w_mul_load;
  logic [5:0]  w_mul_opcode;
  logic [31:0] w_mul_result;
  logic [4:0]  w_mul_dest;

  logic        r_out_valid;
  logic [5:0]  r_out_opcode;
  logic [31:0] r_out_result;
  logic [4:0]  r_out_dest;
  logic        r_out_wen;

  assign w_opcode = id_ex[106:101];
  assign w_a      = id_ex[100:69];
  assign w_b      = id_ex[68:37];
  assign w_dest   = id_ex[36:32];
  assign w_imm    = id_ex[31:0];
  // I-type opcodes all live in the 001xxx group, so bit 3 picks the immediate
  assign w_op2    = w_opcode[3] ? w_imm : w_b;
  assign w_accept = in_valid && in_ready;

  // Single-cycle ALU decode; unknown opcodes fall through as NOP with result 0
  always_comb begin
    w_alu_result = 32'd0;
    w_alu_known  = 1'b1;
    case (w_opcode)
      c_op_add, c_op_addi: w_alu_result = w_a + w_op2;
      c_op_sub, c_op_subi: w_alu_result = w_a - w_op2;
      c_op_and, c_op_andi: w_alu_result = w_a & w_op2;
      c_op_or,  c_op_ori:  w_alu_result = w_a | w_op2;
      c_op_slt, c_op_slti: w_alu_result = {31'd0, ($signed(w_a) < $signed(w_op2))};
      default:             w_alu_known  = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_next;
  end

`ifdef EX_MUL_EN
  logic        w_is_mul;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [4:0]  r_mul_cnt;
  logic [4:0]  r_mul_dest;

  assign w_is_mul   = (w_opcode == c_op_mul);
  assign w_load_alu = w_accept && !w_is_mul;

  // Next-state: one busy cycle per multiplier bit, then DONE commits the product
  always_comb begin
    w_state_next = c_st_idle;
    case (r_state)
      c_st_idle:     w_state_next = (w_accept && w_is_mul) ? c_st_mul_busy : c_st_idle;
      c_st_mul_busy: w_state_next = (r_mul_cnt == 5'd31) ? c_st_done : c_st_mul_busy;
      c_st_done:     w_state_next = c_st_idle;
      default:       w_state_next = c_st_idle;
    endcase
  end

  // Shift-add multiplier: consume one multiplier bit per busy cycle, low 32 bits only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand    <= 32'd0;
      r_mplier   <= 32'd0;
      r_acc      <= 32'd0;
      r_mul_cnt  <= 5'd0;
      r_mul_dest <= 5'd0;
    end else if (r_state == c_st_idle && w_accept && w_is_mul) begin
      r_mcand    <= w_a;
      r_mplier   <= w_b;
      r_acc      <= 32'd0;
      r_mul_cnt  <= 5'd0;
      r_mul_dest <= w_dest;
    end else if (r_state == c_st_mul_busy) begin
      r_acc      <= r_acc + (r_mplier[0] ? r_mcand : 32'd0);
      r_mcand    <= {r_mcand[30:0], 1'b0};
      r_mplier   <= {1'b0, r_mplier[31:1]};
      r_mul_cnt  <= r_mul_cnt + 5'd1;
    end
  end

  assign w_mul_load   = (r_state == c_st_done);
  assign w_mul_opcode = c_op_mul;
  assign w_mul_result = r_acc;
  assign w_mul_dest   = r_mul_dest;
`else
  assign w_load_alu = w_accept;

  // Next-state: without the multiplier the stage never leaves IDLE
  always_comb begin
    w_state_next = c_st_idle;
    case (r_state)
      default: w_state_next = c_st_idle;
    endcase
  end

  assign w_mul_load   = 1'b0;
  assign w_mul_opcode = 6'd0;
  assign w_mul_result = 32'd0;
  assign w_mul_dest   = 5'd0;
`endif

  // Output decode: accept only when idle and the result slot is free or draining
  always_comb begin
    in_ready = (r_state == c_st_idle) && (!r_out_valid || out_ready);
  end

  // Result register: a new load wins over a drain so streaming keeps out_valid high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_opcode <= 6'd0;
      r_out_result <= 32'd0;
      r_out_dest   <= 5'd0;
      r_out_wen    <= 1'b0;
    end else if (w_load_alu) begin
      r_out_valid  <= 1'b1;
      r_out_opcode <= w_opcode;
      r_out_result <= w_alu_result;
      r_out_dest   <= w_dest;
      r_out_wen    <= w_alu_known && (w_dest != 5'd0);
    end else if (w_mul_load) begin
      r_out_valid  <= 1'b1;
      r_out_opcode <= w_mul_opcode;
      r_out_result <= w_mul_result;
      r_out_dest   <= w_mul_dest;
      r_out_wen    <= (w_mul_dest != 5'd0);
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_opcode = r_out_opcode;
  assign out_result = r_out_result;
  assign out_dest   = r_out_dest;
  assign out_wen    = r_out_wen;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_execute_stage                                             |
// | Description : Self-checking bench for execute_stage: directed vectors      |
// |               followed by a randomized stream scored against a reference   |
// |               model. Honours EX_MUL_EN the same way as the design.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_execute_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [106:0] id_ex;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_opcode;
  logic [31:0]  out_result;
  logic [4:0]   out_dest;
  logic         out_wen;

  int checks   = 0;
  int failures = 0;

  logic [43:0] q[$];

  execute_stage dut (
    .clk        (clk),
    .reset      (reset),
    .id_ex      (id_ex),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_result (out_result),
    .out_dest   (out_dest),
    .out_wen    (out_wen)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] bundle();
    return {out_opcode, out_result, out_dest, out_wen};
  endfunction

  // Reference: what the instruction retires as, from the opcode table
  function automatic logic [43:0] ref_exec(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] d,
                                           input logic [31:0] im);
    logic [31:0] o2;
    logic [31:0] r;
    logic        ok;
    o2 = (op >= 6'd8 && op <= 6'd12) ? im : b;
    ok = 1'b1;
    r  = 32'd0;
    case (op)
      6'd0, 6'd8:  r = a + o2;
      6'd1, 6'd9:  r = a - o2;
      6'd2, 6'd10: r = a & o2;
      6'd3, 6'd11: r = a | o2;
      6'd4, 6'd12: r = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
      6'd5:        r = a * b;
`endif
      default:     ok = 1'b0;
    endcase
    if (!ok) r = 32'd0;
    return {op, r, d, ok && (d != 5'd0)};
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] im);
    int guard;
    guard    = 0;
    id_ex    = {op, a, b, d, im};
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    chk("issue_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [43:0] exp_b;
    logic [43:0] held;
    logic        was_stalled;
    int          stray;
    logic [5:0]  op;
    logic [31:0] a, b, im;
    logic [4:0]  d;

    reset = 1'b1; in_valid = 1'b0; id_ex = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_bundle", 64'(bundle()), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ADD wraps modulo 2^32
    out_ready = 1'b1;
    issue(6'd0, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'd0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_bundle", 64'(bundle()), 64'({6'd0, 32'h1, 5'd3, 1'b1}));

    // Signed compares
    issue(6'd12, 32'hFFFF_FFFE, 32'd0, 5'd4, 32'h1);
    chk("slti_bundle", 64'(bundle()), 64'({6'd12, 32'h1, 5'd4, 1'b1}));
    issue(6'd4, 32'd5, 32'h8000_0000, 5'd5, 32'd0);
    chk("slt_bundle", 64'(bundle()), 64'({6'd4, 32'h0, 5'd5, 1'b1}));

    // Back-pressure hold
    issue(6'd1, 32'd10, 32'd3, 5'd6, 32'd0);
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(out_result), 64'd7);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_valid", 64'(out_valid), 64'd1);
    tick();
    chk("after_release_valid", 64'(out_valid), 64'd0);

    // MUL
    issue(6'd5, 32'h0001_0001, 32'h0001_0000, 5'd7, 32'd0);
`ifdef EX_MUL_EN
    for (int k = 0; k < 33; k++) begin
      chk("mul_busy_in_ready", 64'(in_ready), 64'd0);
      chk("mul_busy_valid", 64'(out_valid), 64'd0);
      tick();
    end
    chk("mul_valid", 64'(out_valid), 64'd1);
    chk("mul_bundle", 64'(bundle()), 64'({6'd5, 32'h0001_0000, 5'd7, 1'b1}));
`else
    chk("mul_nop_valid", 64'(out_valid), 64'd1);
    chk("mul_nop_bundle", 64'(bundle()), 64'({6'd5, 32'h0, 5'd7, 1'b0}));
`endif
    tick();

    // Reset in the middle of a MUL must drop it silently
    issue(6'd5, 32'h1234_5678, 32'h9ABC_DEF1, 5'd8, 32'd0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_result", 64'(out_result), 64'd0);
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) stray++;
      tick();
    end
    chk("midrst_no_stale", 64'(stray), 64'd0);

    // Streaming at one per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    id_ex = {6'd3, 32'hF0F0_0000, 32'h0000_0F0F, 5'd1, 32'd0};
    #1;
    chk("stream_or_ready", 64'(in_ready), 64'd1);
    tick();
    chk("stream_or_bundle", 64'({out_valid, bundle()}), 64'({1'b1, 6'd3, 32'hF0F0_0F0F, 5'd1, 1'b1}));
    id_ex = {6'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd2, 32'd0};
    #1;
    chk("stream_and_ready", 64'(in_ready), 64'd1);
    tick();
    chk("stream_and_bundle", 64'({out_valid, bundle()}), 64'({1'b1, 6'd2, 32'h0F00_0F00, 5'd2, 1'b1}));
    id_ex = {6'd8, 32'd5, 32'd0, 5'd0, 32'd7};
    #1;
    chk("stream_addi_ready", 64'(in_ready), 64'd1);
    tick();
    chk("stream_addi_bundle", 64'({out_valid, bundle()}), 64'({1'b1, 6'd8, 32'hC, 5'd0, 1'b0}));
    in_valid = 1'b0;

    // Undefined opcode retires as NOP
    issue(6'h3F, 32'd1, 32'd2, 5'd9, 32'd3);
    chk("nop_bundle", 64'({out_valid, bundle()}), 64'({1'b1, 6'h3F, 32'h0, 5'd9, 1'b0}));
    tick();

    // Randomized stream against the reference model
    was_stalled = 1'b0;
    held        = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      case ($urandom_range(0, 15))
        0, 1, 2, 3, 4, 5: op = 6'($urandom_range(0, 5));
        6, 7, 8, 9, 10:   op = 6'($urandom_range(8, 12));
        default:          op = 6'($urandom_range(0, 63));
      endcase
      a  = rand_val();
      b  = rand_val();
      im = rand_val();
      d  = 5'($urandom_range(0, 31));
      id_ex     = {op, a, b, d, im};
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (was_stalled) chk("rnd_hold", 64'({out_valid, bundle()}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (q.size() > 0) exp_b = q.pop_front();
        else              exp_b = 'x;
        chk("rnd_out", 64'(bundle()), 64'(exp_b));
      end
      if (in_valid && in_ready) q.push_back(ref_exec(op, a, b, d, im));
      was_stalled = out_valid && !out_ready;
      held        = bundle();
      tick();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (out_valid) begin
        if (q.size() > 0) exp_b = q.pop_front();
        else              exp_b = 'x;
        chk("drain_out", 64'(bundle()), 64'(exp_b));
      end
      tick();
      if (q.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
